// File: rtl/ahb3lite_slave_mux.sv
// ============================================================================
// Module   : ahb3lite_slave_mux
// Purpose  : AHB3-Lite address decoder / response mux with built-in default
//            ERROR slave. Optional error address log under AHB3LITE_ERRLOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ahb3lite_slave_mux #(
  parameter int                                 SLAVES      = 4,
  parameter int                                 HADDR_SIZE  = 32,
  parameter int                                 HDATA_SIZE  = 32,
  parameter logic [SLAVES-1:0][HADDR_SIZE-1:0]  SLAVE_BASE  = '0,
  parameter logic [SLAVES-1:0][HADDR_SIZE-1:0]  SLAVE_MASK  = '0,
  localparam int                                HTRANS_SIZE = 2
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic [HADDR_SIZE-1:0]        HADDR,
  input  logic [HTRANS_SIZE-1:0]       HTRANS,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [HDATA_SIZE-1:0]        HRDATA,
  output logic [SLAVES-1:0]            slv_HSEL,
  input  logic [SLAVES-1:0]            slv_HREADYOUT,
  input  logic [SLAVES-1:0]            slv_HRESP,
  input  logic [SLAVES*HDATA_SIZE-1:0] slv_HRDATA
`ifdef AHB3LITE_ERRLOG_EN
  ,
  output logic                         err_valid,
  output logic [HADDR_SIZE-1:0]        err_addr,
  input  logic                         err_clr
`endif
);

  localparam int                     c_SEL_W        = (SLAVES > 1) ? $clog2(SLAVES) : 1;
  localparam logic [HTRANS_SIZE-1:0] c_HTRANS_IDLE  = 2'b00;
  localparam logic [HTRANS_SIZE-1:0] c_HTRANS_NSEQ  = 2'b10;
  localparam logic [HTRANS_SIZE-1:0] c_HTRANS_SEQ   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_state_t;

  logic [SLAVES-1:0]  w_hit;
  logic [SLAVES-1:0]  w_hsel;
  logic [c_SEL_W-1:0] w_idx;
  logic               w_found;
  logic               w_miss;
  logic               w_err_start;

  logic [c_SEL_W-1:0] r_dsel;
  logic               r_dsel_def;
  logic               r_dact;

  def_state_t         r_state;
  def_state_t         w_state_nxt;
  logic               r_def_hready;
  logic               r_def_hresp;
  logic               w_def_hready_nxt;
  logic               w_def_hresp_nxt;

  generate
    for (genvar gi = 0; gi < SLAVES; gi++) begin : g_hit
      assign w_hit[gi] = (SLAVE_MASK[gi] != '0) &&
                         ((HADDR & SLAVE_MASK[gi]) == (SLAVE_BASE[gi] & SLAVE_MASK[gi]));
    end
  endgenerate

  // Lowest-index hit wins on overlapping regions
  always_comb begin
    w_hsel  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < SLAVES; i++) begin
      if (w_hit[i] && !w_found) begin
        w_hsel[i] = 1'b1;
        w_idx     = c_SEL_W'(i);
        w_found   = 1'b1;
      end
    end
  end

  assign w_miss   = ~w_found;
  assign slv_HSEL = w_hsel;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_dsel     <= '0;
      r_dsel_def <= 1'b1;
      r_dact     <= 1'b0;
    end else if (HREADY) begin
      r_dsel     <= w_idx;
      r_dsel_def <= w_miss;
      r_dact     <= (HTRANS != c_HTRANS_IDLE);
    end
  end

  // Default-slave responses only matter for an active data phase
  always_comb begin
    HREADY = r_def_hready | ~r_dact;
    HRESP  = r_def_hresp & r_dact;
    HRDATA = '0;
    if (!r_dsel_def) begin
      HREADY = slv_HREADYOUT[r_dsel];
      HRESP  = slv_HRESP[r_dsel];
      HRDATA = slv_HRDATA[r_dsel*HDATA_SIZE +: HDATA_SIZE];
    end
  end

  assign w_err_start = HREADY && w_miss &&
                       ((HTRANS == c_HTRANS_NSEQ) || (HTRANS == c_HTRANS_SEQ));

  always_comb begin
    w_state_nxt      = r_state;
    w_def_hready_nxt = 1'b1;
    w_def_hresp_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: if (w_err_start) w_state_nxt = ST_ERR1;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = w_err_start ? ST_ERR1 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    case (w_state_nxt)
      ST_ERR1: begin
        w_def_hready_nxt = 1'b0;
        w_def_hresp_nxt  = 1'b1;
      end
      ST_ERR2: w_def_hresp_nxt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= ST_IDLE;
      r_def_hready <= 1'b1;
      r_def_hresp  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_def_hready <= w_def_hready_nxt;
      r_def_hresp  <= w_def_hresp_nxt;
    end
  end

`ifdef AHB3LITE_ERRLOG_EN
  logic                  r_err_valid;
  logic [HADDR_SIZE-1:0] r_err_addr;
  logic                  w_capture;

  // A clear in the same cycle frees the log so the new error is taken
  assign w_capture = (r_state == ST_IDLE) && (w_state_nxt == ST_ERR1) &&
                     (!r_err_valid || err_clr);

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_capture) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= HADDR;
    end else if (err_clr) begin
      r_err_valid <= 1'b0;
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ahb3lite_slave_mux.sv
// ============================================================================
// Module   : tb_ahb3lite_slave_mux
// Purpose  : Directed scoreboard bench for ahb3lite_slave_mux (2 slaves).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ahb3lite_slave_mux;

  localparam logic [1:0][31:0] c_BASE = {32'h1000_0000, 32'h0000_0000};
  localparam logic [1:0][31:0] c_MASK = {32'hFFFF_0000, 32'hFFFF_0000};
  localparam logic [1:0] c_IDLE = 2'b00;
  localparam logic [1:0] c_BUSY = 2'b01;
  localparam logic [1:0] c_NSEQ = 2'b10;

  logic        HCLK;
  logic        HRESET;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic [1:0]  slv_HSEL;
  logic [1:0]  slv_HREADYOUT;
  logic [1:0]  slv_HRESP;
  logic [63:0] slv_HRDATA;
`ifdef AHB3LITE_ERRLOG_EN
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_clr;
`endif

  ahb3lite_slave_mux #(
    .SLAVES     (2),
    .HADDR_SIZE (32),
    .HDATA_SIZE (32),
    .SLAVE_BASE (c_BASE),
    .SLAVE_MASK (c_MASK)
  ) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .HADDR         (HADDR),
    .HTRANS        (HTRANS),
    .HREADY        (HREADY),
    .HRESP         (HRESP),
    .HRDATA        (HRDATA),
    .slv_HSEL      (slv_HSEL),
    .slv_HREADYOUT (slv_HREADYOUT),
    .slv_HRESP     (slv_HRESP),
    .slv_HRDATA    (slv_HRDATA)
`ifdef AHB3LITE_ERRLOG_EN
    ,
    .err_valid     (err_valid),
    .err_addr      (err_addr),
    .err_clr       (err_clr)
`endif
  );

  typedef struct packed {
    logic        rdy;
    logic        resp;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   n_total = 0;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic master(input logic [31:0] a, input logic [1:0] t);
    HADDR  = a;
    HTRANS = t;
  endtask

  task automatic slaves(input logic r0, input logic r1, input logic [31:0] d0, input logic [31:0] d1);
    slv_HREADYOUT = {r1, r0};
    slv_HRDATA    = {d1, d0};
  endtask

  task automatic push(input logic r, input logic e, input logic [31:0] d);
    sb.push_back(exp_t'({r, e, d}));
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare the current data-phase response against the next scoreboard entry
  task automatic chk_resp(input string tag);
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      n_total++;
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed rdy=%b resp=%b data=%h", tag, HREADY, HRESP, HRDATA);
    end else begin
      e = sb.pop_front();
      check(tag, {29'd0, HREADY, HRESP, HRDATA}, {29'd0, e.rdy, e.resp, e.data});
    end
  endtask

  initial begin
    HRESET    = 1'b1;
    slv_HRESP = 2'b00;
`ifdef AHB3LITE_ERRLOG_EN
    err_clr   = 1'b0;
`endif
    master(32'h1000_0004, c_IDLE);
    slaves(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF);
    #2;
    check("rst_hready", {63'd0, HREADY}, 64'd1);
    check("rst_hresp",  {63'd0, HRESP},  64'd0);
    check("rst_hrdata", {32'd0, HRDATA}, 64'd0);
    check("rst_hsel",   {62'd0, slv_HSEL}, 64'd2);
    tick();
    tick();
    HRESET = 1'b0;

    // Read from slave 1
    push(1'b1, 1'b0, 32'h0);
    tick(); master(32'h1000_0004, c_NSEQ); slaves(1'b1, 1'b1, 32'h0, 32'h0);
    chk_resp("c1_idle");
    check("c1_hsel", {62'd0, slv_HSEL}, 64'd2);
    push(1'b1, 1'b0, 32'hCAFE_F00D);

    tick(); master(32'h0000_0010, c_NSEQ); slaves(1'b1, 1'b1, 32'h0, 32'hCAFE_F00D);
    chk_resp("c2_rd_s1");
    check("c2_hsel", {62'd0, slv_HSEL}, 64'd1);
    for (int i = 0; i < 3; i++) push(1'b0, 1'b0, 32'h0);
    push(1'b1, 1'b0, 32'h1234_5678);

    // Slave 0 inserts three wait states while HADDR moves to slave 1
    tick(); master(32'h1000_0000, c_NSEQ); slaves(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    chk_resp("c3_wait");
    check("c3_hsel", {62'd0, slv_HSEL}, 64'd2);
    tick(); slaves(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    chk_resp("c4_wait");
    tick(); slaves(1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF);
    chk_resp("c5_wait");

    tick(); master(32'h2000_0000, c_NSEQ); slaves(1'b1, 1'b1, 32'h1234_5678, 32'hDEAD_BEEF);
    chk_resp("c6_rd_s0");
    check("c6_hsel_miss", {62'd0, slv_HSEL}, 64'd0);
    push(1'b0, 1'b1, 32'h0);
    push(1'b1, 1'b1, 32'h0);

    // Unmapped NONSEQ: two-cycle ERROR, then OKAY
    tick(); slaves(1'b1, 1'b1, 32'h0, 32'h0);
    chk_resp("c7_err1");
    tick(); master(32'h0000_0000, c_IDLE);
    chk_resp("c8_err2");
    push(1'b1, 1'b0, 32'h0);

    tick(); master(32'h2000_0000, c_NSEQ);
    chk_resp("c9_okay");
    push(1'b0, 1'b1, 32'h0);
    push(1'b1, 1'b1, 32'h0);

    // Back-to-back errors: second request presented during ERR2
    tick();
    chk_resp("c10_err1");
    tick(); master(32'h3000_0000, c_NSEQ);
    chk_resp("c11_err2");
    push(1'b0, 1'b1, 32'h0);
    push(1'b1, 1'b1, 32'h0);
    tick();
    chk_resp("c12_err1b");
    tick(); master(32'h2000_0000, c_IDLE);
    chk_resp("c13_err2b");
    push(1'b1, 1'b0, 32'h0);

    // IDLE and BUSY to unmapped space complete with zero-wait OKAY
    tick(); master(32'h2000_0000, c_BUSY);
    chk_resp("c14_idle_unmapped");
    push(1'b1, 1'b0, 32'h0);
    tick(); master(32'h2000_0000, c_NSEQ);
    chk_resp("c15_busy_unmapped");
    push(1'b0, 1'b1, 32'h0);

    // Reset pulse in ERR1 drops the pending error
    tick();
    chk_resp("c16_err1");
    #1; HRESET = 1'b1;
    #1;
    check("c16_rst_hready", {62'd0, HREADY, HRESP}, 64'd2);
    #2; HRESET = 1'b0; master(32'h0000_0000, c_IDLE);
    push(1'b1, 1'b0, 32'h0);
    push(1'b1, 1'b0, 32'h0);
    tick();
    chk_resp("c17_after_rst");
    tick();
    chk_resp("c18_after_rst");

`ifdef AHB3LITE_ERRLOG_EN
    check("log_rst_valid", {63'd0, err_valid}, 64'd0);
    tick(); master(32'h2000_0000, c_NSEQ);
    tick();
    tick(); master(32'h3000_0000, c_NSEQ);
    tick();
    tick(); master(32'h0000_0000, c_IDLE);
    tick(); #1;
    check("log_first", {31'd0, err_valid, err_addr}, {31'd0, 1'b1, 32'h2000_0000});
    master(32'h4000_0000, c_NSEQ); err_clr = 1'b1;
    tick(); err_clr = 1'b0; #1;
    check("log_clr_capture", {31'd0, err_valid, err_addr}, {31'd0, 1'b1, 32'h4000_0000});
    tick(); master(32'h0000_0000, c_IDLE);
    tick(); err_clr = 1'b1;
    tick(); err_clr = 1'b0; #1;
    check("log_cleared", {63'd0, err_valid}, 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ahb3lite_slave_mux.md
Name: ahb3lite_slave_mux

Overview:
- Address decoder and response multiplexer for one AHB3-Lite master driving SLAVES slave ports.
- Decodes HADDR in the address phase and drives one-hot slave selects.
- Tracks the selected slave into the data phase and routes that slave's HREADYOUT, HRESP and HRDATA back to the master.
- Accesses that hit no slave region are terminated by an internal default-slave sequencer with the standard two-cycle ERROR response.

Parameters:
- SLAVES, 4: number of slave ports (1..16).
- HADDR_SIZE, 32: address bus width.
- HDATA_SIZE, 32: data bus width.
- SLAVE_BASE, all zero: packed [SLAVES][HADDR_SIZE] region base addresses.
- SLAVE_MASK, all zero: packed [SLAVES][HADDR_SIZE] region masks. A mask of all-zero disables that port.

Ports:
- HCLK in 1: bus clock, rising edge.
- HRESET in 1: asynchronous, active-high reset.
- HADDR in HADDR_SIZE: master address.
- HTRANS in HTRANS_SIZE: master transfer type.
- HREADY out 1: combined ready to the master, also broadcast to all slaves.
- HRESP out 1: response to the master.
- HRDATA out HDATA_SIZE: read data to the master.
- slv_HSEL out SLAVES: one-hot address-phase select.
- slv_HREADYOUT in SLAVES: per-slave ready.
- slv_HRESP in SLAVES: per-slave response.
- slv_HRDATA in SLAVES*HDATA_SIZE: per-slave read data; slave i occupies bits [i*HDATA_SIZE +: HDATA_SIZE].

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Clock is HCLK, reset is HRESET.
- Decode (combinational): hit[i] = SLAVE_MASK[i]!=0 && (HADDR & SLAVE_MASK[i]) == (SLAVE_BASE[i] & SLAVE_MASK[i]).
  - On overlapping regions, the lowest index wins.
  - slv_HSEL is one-hot or all-zero; it is not qualified by HTRANS (slaves qualify it themselves).
  - miss = no hit.
- Data-phase select register dsel (index or DEFAULT) and flag dact:
  - Both update only when HREADY=1.
  - dsel <= winning index, or DEFAULT on miss.
  - dact <= (HTRANS != HTRANS_IDLE).
- Response mux, when dsel = slave i:
  - HREADY = slv_HREADYOUT[i], HRESP = slv_HRESP[i], HRDATA = slice i.
  - Slave responses pass through untouched, including slave-generated ERROR and wait states.
- Response mux, when dsel = DEFAULT: HREADY and HRESP come from the default FSM; HRDATA = 0.
- Default FSM states: IDLE, ERR1, ERR2. Outputs are registered.
  - IDLE (HREADY=1, HRESP=OKAY): on HREADY && miss && HTRANS in {NONSEQ, SEQ} -> ERR1; otherwise stay in IDLE.
  - ERR1 (HREADY=0, HRESP=ERROR): always -> ERR2.
  - ERR2 (HREADY=1, HRESP=ERROR): the next address phase is sampled this cycle.
    - A new unmapped NONSEQ/SEQ -> ERR1 (back-to-back errors).
    - Otherwise -> IDLE.
- BUSY or IDLE transfers to an unmapped address get a zero-wait OKAY.
- Transfers to a mapped slave never enter ERR1.
- Reset values:
  - FSM = IDLE, dsel = DEFAULT, dact = 0.
  - HREADY = 1, HRESP = OKAY, HRDATA = 0.
  - slv_HSEL follows HADDR combinationally.
- Reset mid-transfer: any state returns to IDLE and dsel to DEFAULT immediately. No error cycle completes after reset deasserts.
- Slave wait states: dsel is held while HREADY=0, and new address-phase decode results are ignored.

Optional Feature:
- Macro AHB3LITE_ERRLOG_EN.
- When defined, three extra ports exist:
  - err_valid out 1
  - err_addr out HADDR_SIZE
  - err_clr in 1
- Capture: on an IDLE->ERR1 transition with err_valid=0, err_addr <= HADDR and err_valid <= 1. The first error is held; later errors do not overwrite it.
- Clear: err_clr=1 clears err_valid on the next edge. If a capture occurs in the same cycle, the capture wins (err_valid stays 1, err_addr is updated).
- Reset: err_valid=0, err_addr=0.
- When not defined: the ports and registers are absent, and behaviour is otherwise identical.

Test Plan:
- SLAVES=2, BASE0=0x0000_0000/MASK0=0xFFFF_0000, BASE1=0x1000_0000/MASK1=0xFFFF_0000. NONSEQ read 0x1000_0004 with slave1 HRDATA=0xCAFEF00D -> slv_HSEL=2'b10; next cycle HRDATA=0xCAFEF00D, HRESP=OKAY.
- Slave0 holds HREADYOUT=0 for 3 cycles -> HREADY=0 for exactly 3 cycles; dsel stays 0 while HADDR changes to slave1 space.
- NONSEQ to 0x2000_0000 -> data phase: cycle 1 HREADY=0/HRESP=ERROR, cycle 2 HREADY=1/HRESP=ERROR, cycle 3 HRESP=OKAY.
- Back-to-back NONSEQ to 0x2000_0000 then 0x3000_0000 (second presented in ERR2) -> two complete ERROR pairs with no OKAY cycle between them; HTRANS=IDLE to 0x2000_0000 -> OKAY, zero wait.
- HRESET pulsed during ERR1 -> HREADY=1, HRESP=OKAY on the next cycle after release; the pending error is dropped.
- With AHB3LITE_ERRLOG_EN: errors at 0x2000_0000 then 0x3000_0000 -> err_addr=0x2000_0000, err_valid=1; err_clr asserted together with a new error at 0x4000_0000 -> err_addr=0x4000_0000, err_valid=1.
